// File: rtl/fp_link_ctrl.sv
// rtl/fp_link_ctrl.sv - U62 front-panel serial link controller
//
// Receives a command byte from U62 over SCK/SDATA, turns the line around,
// returns the drive status byte, then releases the line. Decoded transport
// commands are handed to the drive sequencer through a one-entry buffer.
//
// Optional build macro: FP_PARITY_EN (9-bit frames with odd parity).
//
// Ports:
//   PI_CLK, RESET_n        system clock, synchronous active-low reset
//   SCK, SDATA_IN          asynchronous link inputs from the pad
//   SDATA_OUT, SDATA_OE    SDATA drive value / drive enable for the top-level tristate
//   status_in              current drive status returned to U62
//   cmd_code, cmd_raw      decoded command (1 PLAY, 2 STOP, 3 REWIND, 4 FF) and raw byte
//   cmd_valid, cmd_ready   command handshake towards the drive sequencer
//   STCH                   status differs from the value last returned to U62
//   link_busy              transaction in progress
//   err_unknown            pulse: unrecognised command (or parity error)
//   err_timeout            pulse: transaction aborted by the watchdog
//   overrun                pulse: pending command overwritten before acceptance

module fp_link_ctrl #(
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       PI_CLK,
   input  logic       RESET_n,
   input  logic       SCK,
   input  logic       SDATA_IN,
   output logic       SDATA_OUT,
   output logic       SDATA_OE,
   input  logic [7:0] status_in,
   output logic [2:0] cmd_code,
   output logic [7:0] cmd_raw,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic       STCH,
   output logic       link_busy,
   output logic       err_unknown,
   output logic       err_timeout,
   output logic       overrun
);

`ifdef FP_PARITY_EN
   localparam int FRAME = 9;
`else
   localparam int FRAME = 8;
`endif
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, RX, TURN, TX, REL} state_t;

   state_t                 state, state_n;
   logic [3:0]             bit_cnt, cnt_n;
   logic [FRAME-1:0]       rx_shift, rx_n;
   logic [FRAME-1:0]       tx_shift, tx_n;
   logic [FRAME-1:0]       rx_frame;
   logic [FRAME-1:0]       tx_load;
   logic [7:0]             rep_status;
   logic [WDW-1:0]         wdog, wdog_n;
   logic                   oe_n, out_n;
   logic                   frame_done, abort;
   logic                   dec_pend;

   logic [SYNC_STAGES-1:0] sck_sync, sda_sync;
   logic                   sck_q;
   logic                   sck_s, sda_s, rise, fall;

   // Both inputs travel through identical chains so a data sample stays
   // aligned with the clock edge detected in the same cycle.
   assign sck_s = sck_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];
   assign rise  = sck_s & ~sck_q;
   assign fall  = ~sck_s & sck_q;

`ifdef FP_PARITY_EN
   assign tx_load = {status_in, ~^status_in};
`else
   assign tx_load = status_in;
`endif

   always_comb begin
      state_n    = state;
      cnt_n      = bit_cnt;
      rx_n       = rx_shift;
      tx_n       = tx_shift;
      oe_n       = SDATA_OE;
      out_n      = SDATA_OUT;
      frame_done = 1'b0;
      abort      = 1'b0;
      wdog_n     = (state == IDLE || rise || fall) ? '0 : wdog + 1'b1;

      case (state)
         IDLE: begin
            if (rise) begin
               rx_n    = {rx_shift[FRAME-2:0], sda_s};
               cnt_n   = 4'd1;
               state_n = RX;
            end
         end
         RX: begin
            if (rise) begin
               rx_n = {rx_shift[FRAME-2:0], sda_s};
               if (bit_cnt == 4'(FRAME - 1)) begin
                  frame_done = 1'b1;
                  tx_n       = tx_load;
                  cnt_n      = 4'd0;
                  state_n    = TURN;
               end else begin
                  cnt_n = bit_cnt + 4'd1;
               end
            end
         end
         TURN: begin
            if (fall) begin
               oe_n    = 1'b1;
               out_n   = tx_shift[FRAME-1];
               tx_n    = {tx_shift[FRAME-2:0], 1'b0};
               state_n = TX;
            end
         end
         TX: begin
            // The first bit was launched by the TURN fall; each later fall
            // launches the next one, and U62 samples on the rises.
            if (fall) begin
               out_n = tx_shift[FRAME-1];
               tx_n  = {tx_shift[FRAME-2:0], 1'b0};
            end
            if (rise) begin
               if (bit_cnt == 4'(FRAME - 1)) begin
                  cnt_n   = 4'd0;
                  state_n = REL;
               end else begin
                  cnt_n = bit_cnt + 4'd1;
               end
            end
         end
         REL: begin
            if (fall) begin
               oe_n    = 1'b0;
               out_n   = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (state != IDLE && !rise && !fall && wdog == WDW'(TIMEOUT_CYCLES - 1)) begin
         abort   = 1'b1;
         state_n = IDLE;
         cnt_n   = 4'd0;
         oe_n    = 1'b0;
         out_n   = 1'b0;
         wdog_n  = '0;
      end
   end

   // Decode stage, one cycle after the last RX rise.
   logic [7:0] rx_byte;
   logic [2:0] dec_code;
   logic       dec_idle, par_ok, new_cmd, bad_cmd;

   assign rx_byte = rx_frame[FRAME-1 -: 8];
`ifdef FP_PARITY_EN
   assign par_ok = ^rx_frame;
`else
   assign par_ok = 1'b1;
`endif

   always_comb begin
      dec_code = 3'd0;
      dec_idle = 1'b0;
      case (rx_byte)
         8'h80:   dec_code = 3'd1;
         8'h60:   dec_code = 3'd2;
         8'h20:   dec_code = 3'd3;
         8'h40:   dec_code = 3'd4;
         8'h08:   dec_idle = 1'b1;
         default: dec_code = 3'd0;
      endcase
   end

   assign new_cmd = dec_pend & par_ok & (dec_code != 3'd0);
   assign bad_cmd = dec_pend & (~par_ok | ((dec_code == 3'd0) & ~dec_idle));

   always_ff @(posedge PI_CLK) begin
      if (!RESET_n) begin
         sck_sync    <= '1;
         sda_sync    <= '1;
         sck_q       <= 1'b1;
         state       <= IDLE;
         bit_cnt     <= 4'd0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         rx_frame    <= '0;
         rep_status  <= 8'h00;
         wdog        <= '0;
         dec_pend    <= 1'b0;
         SDATA_OUT   <= 1'b0;
         SDATA_OE    <= 1'b0;
         cmd_code    <= 3'd0;
         cmd_raw     <= 8'h00;
         cmd_valid   <= 1'b0;
         STCH        <= 1'b0;
         link_busy   <= 1'b0;
         err_unknown <= 1'b0;
         err_timeout <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         sck_sync    <= {sck_sync[SYNC_STAGES-2:0], SCK};
         sda_sync    <= {sda_sync[SYNC_STAGES-2:0], SDATA_IN};
         sck_q       <= sck_s;
         state       <= state_n;
         bit_cnt     <= cnt_n;
         rx_shift    <= rx_n;
         tx_shift    <= tx_n;
         wdog        <= wdog_n;
         SDATA_OUT   <= out_n;
         SDATA_OE    <= oe_n;
         link_busy   <= (state_n != IDLE);
         dec_pend    <= frame_done;
         err_timeout <= abort;
         err_unknown <= bad_cmd;
         overrun     <= 1'b0;
         STCH        <= (status_in != rep_status);

         if (frame_done) begin
            rx_frame   <= rx_n;
            rep_status <= status_in;
         end

         // A same-cycle accept frees the slot, so the new command is not an overrun.
         if (new_cmd) begin
            cmd_code  <= dec_code;
            cmd_raw   <= rx_byte;
            cmd_valid <= 1'b1;
            overrun   <= cmd_valid & ~cmd_ready;
         end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fp_link_ctrl.sv
// tb/tb_fp_link_ctrl.sv - directed bench for fp_link_ctrl

module tb_fp_link_ctrl;

   localparam int T = 64;
   localparam int H = 6;

   logic       PI_CLK = 1'b0;
   logic       RESET_n = 1'b0;
   logic       SCK = 1'b1;
   logic       SDATA_IN = 1'b1;
   logic       cmd_ready = 1'b0;
   logic [7:0] status_in = 8'h00;
   logic       SDATA_OUT, SDATA_OE, cmd_valid, STCH, link_busy;
   logic       err_unknown, err_timeout, overrun;
   logic [2:0] cmd_code;
   logic [7:0] cmd_raw;

   int total = 0;
   int bad = 0;
   int n_unk = 0;
   int n_tmo = 0;
   int n_ovr = 0;

   fp_link_ctrl #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) dut (
      .PI_CLK(PI_CLK), .RESET_n(RESET_n), .SCK(SCK), .SDATA_IN(SDATA_IN),
      .SDATA_OUT(SDATA_OUT), .SDATA_OE(SDATA_OE), .status_in(status_in),
      .cmd_code(cmd_code), .cmd_raw(cmd_raw), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .STCH(STCH), .link_busy(link_busy),
      .err_unknown(err_unknown), .err_timeout(err_timeout), .overrun(overrun)
   );

   always #5 PI_CLK = ~PI_CLK;

   always @(negedge PI_CLK) begin
      n_unk = n_unk + (err_unknown ? 1 : 0);
      n_tmo = n_tmo + (err_timeout ? 1 : 0);
      n_ovr = n_ovr + (overrun ? 1 : 0);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sck_bit(input logic d);
      SCK = 1'b0;
      SDATA_IN = d;
      repeat (H) @(negedge PI_CLK);
      SCK = 1'b1;
      repeat (H) @(negedge PI_CLK);
   endtask

   task automatic rx_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) sck_bit(b[i]);
   endtask

   task automatic frame(input logic [7:0] b, input logic chg, input logic [7:0] chg_val,
                        output logic [7:0] txb, output logic oe_ok);
      rx_byte(b);
      oe_ok = 1'b1;
      txb = 8'h00;
      for (int k = 0; k < 8; k++) begin
         SCK = 1'b0;
         repeat (H) @(negedge PI_CLK);
         txb[7-k] = SDATA_OUT;
         if (!SDATA_OE || !link_busy) oe_ok = 1'b0;
         if (chg && k == 3) status_in = chg_val;
         SCK = 1'b1;
         repeat (H) @(negedge PI_CLK);
      end
      SCK = 1'b0;
      repeat (H) @(negedge PI_CLK);
      if (SDATA_OE || link_busy) oe_ok = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] txb;
      logic       ok;
      int         base, lat;

      repeat (3) @(negedge PI_CLK);
      RESET_n = 1'b1;
      @(negedge PI_CLK);
      check("rst_oe", SDATA_OE, 0);
      check("rst_out", SDATA_OUT, 0);
      check("rst_valid", cmd_valid, 0);
      check("rst_code", cmd_code, 0);
      check("rst_raw", cmd_raw, 0);
      check("rst_stch", STCH, 0);
      check("rst_busy", link_busy, 0);
      check("rst_pulses", {err_unknown, err_timeout, overrun}, 0);

      status_in = 8'hA5;
      frame(8'h80, 1'b0, 8'h00, txb, ok);
      check("play_tx", txb, 8'hA5);
      check("play_oe", ok, 1);
      check("play_valid", cmd_valid, 1);
      check("play_code", cmd_code, 1);
      check("play_raw", cmd_raw, 8'h80);
      cmd_ready = 1'b1;
      @(negedge PI_CLK);
      cmd_ready = 1'b0;
      check("play_accept", cmd_valid, 0);

      base = n_ovr;
      frame(8'h60, 1'b0, 8'h00, txb, ok);
      check("stop_code", cmd_code, 2);
      frame(8'h20, 1'b0, 8'h00, txb, ok);
      check("ovr_pulse", n_ovr - base, 1);
      check("rew_code", cmd_code, 3);
      check("rew_raw", cmd_raw, 8'h20);
      check("rew_valid", cmd_valid, 1);
      cmd_ready = 1'b1;
      @(negedge PI_CLK);
      cmd_ready = 1'b0;
      check("rew_accept", cmd_valid, 0);

      base = n_unk;
      frame(8'h08, 1'b0, 8'h00, txb, ok);
      check("idle_valid", cmd_valid, 0);
      check("idle_noerr", n_unk - base, 0);
      frame(8'h13, 1'b0, 8'h00, txb, ok);
      check("unk_pulse", n_unk - base, 1);
      check("unk_raw", cmd_raw, 8'h20);
      check("unk_valid", cmd_valid, 0);

      base = n_tmo;
      sck_bit(1'b1);
      sck_bit(1'b0);
      sck_bit(1'b1);
      SCK = 1'b0;
      SDATA_IN = 1'b1;
      repeat (H) @(negedge PI_CLK);
      SCK = 1'b1;
      lat = 0;
      for (int c = 1; c <= T + 20 && lat == 0; c++) begin
         @(negedge PI_CLK);
         if (err_timeout) lat = c;
      end
      check("tmo_latency", lat, T + 3);
      @(negedge PI_CLK);
      check("tmo_count", n_tmo - base, 1);
      check("tmo_busy", link_busy, 0);
      check("tmo_oe", SDATA_OE, 0);
      frame(8'h40, 1'b0, 8'h00, txb, ok);
      check("ff_code", cmd_code, 4);
      check("ff_valid", cmd_valid, 1);
      cmd_ready = 1'b1;
      @(negedge PI_CLK);
      cmd_ready = 1'b0;

      status_in = 8'h00;
      frame(8'h08, 1'b0, 8'h00, txb, ok);
      repeat (2) @(negedge PI_CLK);
      check("stch_low", STCH, 0);
      status_in = 8'h01;
      @(negedge PI_CLK);
      check("stch_rise", STCH, 1);
      frame(8'h08, 1'b0, 8'h00, txb, ok);
      check("stch_tx1", txb, 8'h01);
      check("stch_clear", STCH, 0);
      frame(8'h08, 1'b1, 8'h03, txb, ok);
      check("stch_tx2", txb, 8'h01);
      check("stch_reassert", STCH, 1);

      frame(8'h60, 1'b0, 8'h00, txb, ok);
      check("pre_rst_valid", cmd_valid, 1);
      rx_byte(8'h80);
      SCK = 1'b0;
      repeat (H) @(negedge PI_CLK);
      SCK = 1'b1;
      repeat (H) @(negedge PI_CLK);
      SCK = 1'b0;
      repeat (H) @(negedge PI_CLK);
      check("mid_tx_oe", SDATA_OE, 1);
      RESET_n = 1'b0;
      @(negedge PI_CLK);
      check("rr_oe", SDATA_OE, 0);
      check("rr_valid", cmd_valid, 0);
      check("rr_stch", STCH, 0);
      check("rr_busy", link_busy, 0);
      RESET_n = 1'b1;
      @(negedge PI_CLK);
      frame(8'h40, 1'b0, 8'h00, txb, ok);
      check("post_rst_code", cmd_code, 4);
      check("post_rst_raw", cmd_raw, 8'h40);
      check("post_rst_valid", cmd_valid, 1);
      check("post_rst_tx", txb, 8'h03);
      check("post_rst_oe", ok, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
